// File: rtl/wt_mem_arbiter_pkg.sv
// wt_mem_arbiter_pkg: shared constants and types
// for the N-channel memory arbiter.
package wt_mem_arbiter_pkg;

  localparam int unsigned L15_TID_WIDTH = 2;
  localparam int unsigned ADAPTER_REQ_FIFO_DEPTH = 3;
  localparam int unsigned ADAPTER_RTRN_FIFO_DEPTH = 2;
  localparam int unsigned MEM_ARB_MAX_OUT = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_PEND
  } arb_state_e;

  function automatic int unsigned mem_arb_ch_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wt_mem_arbiter_fifo.sv
// wt_mem_arbiter_fifo: small synchronous FIFO with
// head exposed combinationally, no push-through when full.
module wt_mem_arbiter_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_cnt == CW'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd];

  // storage, pointers and fill level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= data_i;
        r_wr        <= ptr_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= ptr_inc(r_rd);
      end
      if (w_push & ~w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop & ~w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wt_mem_arbiter.sv
// wt_mem_arbiter: round-robin N-channel request arbiter
// and tag-routed return path to the L1.5/L2 port.
module wt_mem_arbiter
  import wt_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned TID_W           = L15_TID_WIDTH,
  parameter int unsigned REQ_W           = 64,
  parameter int unsigned RTRN_W          = 256,
  parameter int unsigned REQ_FIFO_DEPTH  = ADAPTER_REQ_FIFO_DEPTH,
  parameter int unsigned RTRN_FIFO_DEPTH = ADAPTER_RTRN_FIFO_DEPTH,
  parameter int unsigned MAX_OUT         = MEM_ARB_MAX_OUT,
  localparam int unsigned CH_W  = mem_arb_ch_w(NUM_CH),
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1),
  localparam int unsigned TAG_W = CH_W + TID_W
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_CH-1:0]             req_valid_i,
  output logic [NUM_CH-1:0]             req_ready_o,
  input  logic [NUM_CH-1:0][REQ_W-1:0]  req_data_i,
  input  logic [NUM_CH-1:0][TID_W-1:0]  req_tid_i,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ack_i,
  output logic [REQ_W-1:0]              mem_req_data_o,
  output logic [TAG_W-1:0]              mem_req_tid_o,
  input  logic                          mem_rtrn_valid_i,
  output logic                          mem_rtrn_ready_o,
  input  logic                          mem_rtrn_bcast_i,
  input  logic [TAG_W-1:0]              mem_rtrn_tid_i,
  input  logic [RTRN_W-1:0]             mem_rtrn_data_i,
  output logic [NUM_CH-1:0]             rtrn_valid_o,
  input  logic [NUM_CH-1:0]             rtrn_ready_i,
  output logic [TID_W-1:0]              rtrn_tid_o,
  output logic [RTRN_W-1:0]             rtrn_data_o,
  output logic                          rtrn_bcast_o,
  output logic                          err_o
);

  localparam int unsigned QW = REQ_W + TID_W;
  localparam int unsigned RW = 1 + TAG_W + RTRN_W;

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic [CH_W-1:0]              r_gnt;
  logic [CH_W-1:0]              r_rr;
  logic [REQ_W-1:0]             r_data;
  logic [TAG_W-1:0]             r_tag;
  logic [NUM_CH-1:0][CNT_W-1:0] r_cnt;
  logic                         r_err;

  logic [NUM_CH-1:0]         w_q_full;
  logic [NUM_CH-1:0]         w_q_empty;
  logic [NUM_CH-1:0]         w_q_pop;
  logic [NUM_CH-1:0][QW-1:0] w_q_head;
  logic [NUM_CH-1:0]         w_elig;
  logic [NUM_CH-1:0]         w_dec;

  logic            w_found;
  logic [CH_W-1:0] w_pick;
  logic [CH_W-1:0] w_idx;
  logic            w_load;
  logic            w_ack;

  logic              w_rq_full;
  logic              w_rq_empty;
  logic              w_rq_vld;
  logic              w_rq_pop;
  logic [RW-1:0]     w_rq_head;
  logic              w_hd_bcast;
  logic [TAG_W-1:0]  w_hd_tag;
  logic [CH_W-1:0]   w_hd_ch;
  logic              w_hd_ok;
  logic              w_err_set;

  for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_req_q
    wt_mem_arbiter_fifo #(
      .W     (QW),
      .DEPTH (REQ_FIFO_DEPTH)
    ) u_req_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (req_valid_i[c]),
      .pop_i   (w_q_pop[c]),
      .data_i  ({req_tid_i[c], req_data_i[c]}),
      .data_o  (w_q_head[c]),
      .full_o  (w_q_full[c]),
      .empty_o (w_q_empty[c])
    );
  end

  assign req_ready_o = ~w_q_full;

  // eligibility and per-channel pop/increment on ack
  always_comb begin
    w_elig  = '0;
    w_q_pop = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      w_elig[c]  = ~w_q_empty[c] &
                   (r_cnt[c] < CNT_W'(MAX_OUT));
      w_q_pop[c] = w_ack & (r_gnt == CH_W'(c));
    end
  end

  // first eligible channel at or after rr pointer
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = r_rr;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
      w_idx = (w_idx == CH_W'(NUM_CH - 1)) ?
              '0 : w_idx + 1'b1;
    end
  end

  // arbiter next state: grant in IDLE, hold until ack
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ack       = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = ARB_PEND;
        end
      end
      ARB_PEND: begin
        if (mem_req_ack_i) begin
          w_ack       = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // arbiter state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // granted payload/tag and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gnt  <= '0;
      r_rr   <= '0;
      r_data <= '0;
      r_tag  <= '0;
    end else begin
      if (w_load) begin
        r_gnt  <= w_pick;
        r_data <= w_q_head[w_pick][REQ_W-1:0];
        r_tag  <= {w_pick,
                   w_q_head[w_pick][QW-1 -: TID_W]};
      end
      if (w_ack) begin
        r_rr <= (r_gnt == CH_W'(NUM_CH - 1)) ?
                '0 : r_gnt + 1'b1;
      end
    end
  end

  assign mem_req_valid_o = (r_state == ARB_PEND);
  assign mem_req_data_o  = r_data;
  assign mem_req_tid_o   = r_tag;

  wt_mem_arbiter_fifo #(
    .W     (RW),
    .DEPTH (RTRN_FIFO_DEPTH)
  ) u_rtrn_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (mem_rtrn_valid_i),
    .pop_i   (w_rq_pop),
    .data_i  ({mem_rtrn_bcast_i, mem_rtrn_tid_i,
               mem_rtrn_data_i}),
    .data_o  (w_rq_head),
    .full_o  (w_rq_full),
    .empty_o (w_rq_empty)
  );

  assign mem_rtrn_ready_o = ~w_rq_full;
  assign w_rq_vld   = ~w_rq_empty;
  assign w_hd_bcast = w_rq_head[RW-1];
  assign w_hd_tag   = w_rq_head[RW-2 -: TAG_W];
  assign w_hd_ch    = w_hd_tag[TAG_W-1 -: CH_W];
  assign w_hd_ok    = ({1'b0, w_hd_ch} <
                       (CH_W + 1)'(NUM_CH));
  assign rtrn_tid_o   = w_hd_tag[TID_W-1:0];
  assign rtrn_data_o  = w_rq_head[RTRN_W-1:0];
  assign rtrn_bcast_o = w_rq_vld & w_hd_bcast;

  // return head routing, pop, decrement and error detect
  always_comb begin
    rtrn_valid_o = '0;
    w_rq_pop     = 1'b0;
    w_dec        = '0;
    w_err_set    = 1'b0;
    unique case (1'b1)
      w_rq_empty: begin
      end
      (w_rq_vld & w_hd_bcast): begin
        rtrn_valid_o = '1;
        w_rq_pop     = &rtrn_ready_i;
      end
      (w_rq_vld & ~w_hd_bcast & ~w_hd_ok): begin
        w_rq_pop  = 1'b1;
        w_err_set = 1'b1;
      end
      (w_rq_vld & ~w_hd_bcast & w_hd_ok): begin
        rtrn_valid_o[w_hd_ch] = 1'b1;
        w_rq_pop = rtrn_ready_i[w_hd_ch];
        if (w_rq_pop) begin
          if (r_cnt[w_hd_ch] == '0) begin
            w_err_set = 1'b1;
          end else begin
            w_dec[w_hd_ch] = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // outstanding counters: inc on ack, dec on return pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (w_q_pop[c] & ~w_dec[c]) begin
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end else if (w_dec[c] & ~w_q_pop[c]) begin
          r_cnt[c] <= r_cnt[c] - 1'b1;
        end
      end
    end
  end

  // sticky protocol error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// tb_wt_mem_arbiter: vector table plus grant scoreboard
// for the 3-channel arbiter configuration.
module tb_wt_mem_arbiter;

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] data;
  } gnt_t;

  typedef struct {
    logic        bcast;
    logic [1:0]  ch;
    logic [1:0]  tid;
    logic [15:0] data;
    logic [2:0]  vmask;
    logic        err;
  } rvec_t;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [2:0]      req_valid = '0;
  logic [2:0]      req_ready;
  logic [2:0][15:0] req_data = '0;
  logic [2:0][1:0] req_tid = '0;
  logic            mem_req_valid;
  logic            mem_req_ack = 1'b0;
  logic [15:0]     mem_req_data;
  logic [3:0]      mem_req_tid;
  logic            mem_rtrn_valid = 1'b0;
  logic            mem_rtrn_ready;
  logic            mem_rtrn_bcast = 1'b0;
  logic [3:0]      mem_rtrn_tid = '0;
  logic [15:0]     mem_rtrn_data = '0;
  logic [2:0]      rtrn_valid;
  logic [2:0]      rtrn_ready = '0;
  logic [1:0]      rtrn_tid;
  logic [15:0]     rtrn_data;
  logic            rtrn_bcast;
  logic            err;

  int    checks = 0;
  int    errors = 0;
  gnt_t  sb[$];
  rvec_t rv[9];
  rvec_t tv;
  int    nv;
  bit    seen;

  wt_mem_arbiter #(
    .NUM_CH          (3),
    .TID_W           (2),
    .REQ_W           (16),
    .RTRN_W          (16),
    .REQ_FIFO_DEPTH  (3),
    .RTRN_FIFO_DEPTH (2),
    .MAX_OUT         (2)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_data_i       (req_data),
    .req_tid_i        (req_tid),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ack_i    (mem_req_ack),
    .mem_req_data_o   (mem_req_data),
    .mem_req_tid_o    (mem_req_tid),
    .mem_rtrn_valid_i (mem_rtrn_valid),
    .mem_rtrn_ready_o (mem_rtrn_ready),
    .mem_rtrn_bcast_i (mem_rtrn_bcast),
    .mem_rtrn_tid_i   (mem_rtrn_tid),
    .mem_rtrn_data_i  (mem_rtrn_data),
    .rtrn_valid_o     (rtrn_valid),
    .rtrn_ready_i     (rtrn_ready),
    .rtrn_tid_o       (rtrn_tid),
    .rtrn_data_o      (rtrn_data),
    .rtrn_bcast_o     (rtrn_bcast),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic set_req(input int ch,
                         input logic [1:0] tid,
                         input logic [15:0] d);
    gnt_t e;
    req_valid[ch] = 1'b1;
    req_tid[ch]   = tid;
    req_data[ch]  = d;
    e.tag  = {2'(ch), tid};
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic take_grant(input string nm);
    gnt_t e;
    bit   ok;
    wait_valid(ok);
    check({nm, "_seen"}, 32'(ok), 32'(1));
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      check({nm, "_tag"}, 32'(mem_req_tid),
            32'(e.tag));
      check({nm, "_data"}, 32'(mem_req_data),
            32'(e.data));
    end else if (ok) begin
      checks++;
      errors++;
      $display("FAIL %s_extra: got tag %0h expected none",
               nm, mem_req_tid);
    end
    if (ok) begin
      mem_req_ack = 1'b1;
      tick();
      mem_req_ack = 1'b0;
    end
  endtask

  task automatic apply_rv(input rvec_t v,
                          input string nm);
    mem_rtrn_valid = 1'b1;
    mem_rtrn_bcast = v.bcast;
    mem_rtrn_tid   = {v.ch, v.tid};
    mem_rtrn_data  = v.data;
    tick();
    mem_rtrn_valid = 1'b0;
    mem_rtrn_bcast = 1'b0;
    check({nm, "_vld"}, 32'(rtrn_valid), 32'(v.vmask));
    check({nm, "_bc"}, 32'(rtrn_bcast), 32'(v.bcast));
    if (v.vmask != 3'b000) begin
      check({nm, "_tid"}, 32'(rtrn_tid), 32'(v.tid));
      check({nm, "_data"}, 32'(rtrn_data),
            32'(v.data));
    end
    rtrn_ready = 3'b111;
    tick();
    rtrn_ready = 3'b000;
    check({nm, "_pop"}, 32'(rtrn_valid), 32'(0));
    check({nm, "_err"}, 32'(err), 32'(v.err));
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_req_rdy"}, 32'(req_ready), 32'(3'b111));
    check({nm, "_mvld"}, 32'(mem_req_valid), 32'(0));
    check({nm, "_mtid"}, 32'(mem_req_tid), 32'(0));
    check({nm, "_mdata"}, 32'(mem_req_data), 32'(0));
    check({nm, "_rrdy"}, 32'(mem_rtrn_ready), 32'(1));
    check({nm, "_rvld"}, 32'(rtrn_valid), 32'(0));
    check({nm, "_rbc"}, 32'(rtrn_bcast), 32'(0));
    check({nm, "_rtid"}, 32'(rtrn_tid), 32'(0));
    check({nm, "_err"}, 32'(err), 32'(0));
  endtask

  initial begin
    rv[0] = '{1'b0, 2'd0, 2'd1, 16'h1001, 3'b001, 1'b0};
    rv[1] = '{1'b0, 2'd1, 2'd2, 16'h1102, 3'b010, 1'b0};
    rv[2] = '{1'b0, 2'd2, 2'd3, 16'h1203, 3'b100, 1'b0};
    rv[3] = '{1'b1, 2'd0, 2'd0, 16'h1300, 3'b111, 1'b0};
    rv[4] = '{1'b0, 2'd1, 2'd0, 16'h5100, 3'b010, 1'b0};
    rv[5] = '{1'b0, 2'd1, 2'd1, 16'h5101, 3'b010, 1'b0};
    rv[6] = '{1'b0, 2'd1, 2'd2, 16'h5102, 3'b010, 1'b1};
    rv[7] = '{1'b0, 2'd3, 2'd0, 16'h5300, 3'b000, 1'b1};
    rv[8] = '{1'b0, 2'd2, 2'd3, 16'h5203, 3'b100, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("init");
    rst_ni = 1'b1;
    tick();

    // two requests per channel, immediate ack
    for (int c = 0; c < 3; c++) begin
      set_req(c, 2'd1, 16'(16'hA000 + c * 16));
    end
    tick();
    req_valid = '0;
    check("lat_t0", 32'(mem_req_valid), 32'(0));
    for (int c = 0; c < 3; c++) begin
      set_req(c, 2'd2, 16'(16'hA001 + c * 16));
    end
    tick();
    req_valid = '0;
    check("lat_t1", 32'(mem_req_valid), 32'(1));
    for (int i = 0; i < 6; i++) begin
      take_grant("rr");
    end

    // returns to each channel and one broadcast
    for (int i = 0; i < 4; i++) begin
      apply_rv(rv[i], "rtrn");
    end

    // ack withheld while new requests arrive
    set_req(0, 2'd0, 16'hB000);
    tick();
    req_valid = '0;
    wait_valid(seen);
    check("hold_seen", 32'(seen), 32'(1));
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_req(1, 2'd1, 16'hB100);
      if (i == 1) set_req(2, 2'd2, 16'hB200);
      tick();
      req_valid = '0;
      check("hold_vld", 32'(mem_req_valid), 32'(1));
      check("hold_tag", 32'(mem_req_tid),
            32'(sb[0].tag));
      check("hold_data", 32'(mem_req_data),
            32'(sb[0].data));
    end
    for (int i = 0; i < 3; i++) begin
      take_grant("hold");
    end

    // ch0 at its outstanding limit until a return
    set_req(0, 2'd3, 16'hC000);
    tick();
    req_valid = '0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req_valid) nv++;
      tick();
    end
    check("maxout_stall", 32'(nv), 32'(0));
    tv = '{1'b0, 2'd0, 2'd3, 16'h2003, 3'b001, 1'b0};
    apply_rv(tv, "maxout_rtrn");
    take_grant("maxout");

    // broadcast held until every channel is ready
    mem_rtrn_valid = 1'b1;
    mem_rtrn_bcast = 1'b1;
    mem_rtrn_tid   = 4'h0;
    mem_rtrn_data  = 16'h3333;
    tick();
    mem_rtrn_valid = 1'b0;
    mem_rtrn_bcast = 1'b0;
    rtrn_ready = 3'b101;
    for (int i = 0; i < 3; i++) begin
      check("bc_vld", 32'(rtrn_valid), 32'(3'b111));
      check("bc_flag", 32'(rtrn_bcast), 32'(1));
      tick();
    end
    check("bc_hold", 32'(rtrn_valid), 32'(3'b111));
    rtrn_ready = 3'b111;
    tick();
    rtrn_ready = 3'b000;
    check("bc_pop", 32'(rtrn_valid), 32'(0));
    check("bc_err", 32'(err), 32'(0));

    // counter underflow and bad channel set err
    for (int i = 4; i < 9; i++) begin
      apply_rv(rv[i], "errv");
    end

    // reset while pending with full queues
    for (int i = 0; i < 3; i++) begin
      req_valid   = 3'b011;
      req_data[0] = 16'(16'hE000 + i);
      req_data[1] = 16'(16'hE100 + i);
      req_tid[0]  = 2'(i);
      req_tid[1]  = 2'(i);
      tick();
    end
    req_valid = '0;
    check("full_ready", 32'(req_ready), 32'(3'b100));
    check("full_pend", 32'(mem_req_valid), 32'(1));
    rtrn_ready     = 3'b000;
    mem_rtrn_valid = 1'b1;
    mem_rtrn_tid   = 4'b1000;
    mem_rtrn_data  = 16'h7777;
    tick();
    tick();
    mem_rtrn_valid = 1'b0;
    check("full_rrdy", 32'(mem_rtrn_ready), 32'(0));
    check("full_rvld", 32'(rtrn_valid), 32'(3'b100));
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    sb.delete();
    tick();

    // clean resume after reset
    set_req(2, 2'd1, 16'hD200);
    tick();
    req_valid = '0;
    take_grant("resume");
    tv = '{1'b0, 2'd2, 2'd1, 16'h4444, 3'b100, 1'b0};
    apply_rv(tv, "resume_rtrn");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
